// File: rtl/color_bank_pkg.sv
// Shared definitions for the colour register bank controller: default geometry
// and the sequencer state encoding.
package color_bank_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BLK = 3'd1,
    ST_RD_MOD   = 3'd2,
    ST_WR       = 3'd3,
    ST_FILL     = 3'd4
  } state_e;

endpackage

// File: rtl/color_bank_ctrl_press_queue.sv
// Small FIFO of pending keypad cell indices; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module press_queue #(
  parameter int AW     = 4,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] din_i,
  output logic [AW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(QDEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/color_bank_ctrl.sv
// Sequencer for the shared 16x3 colour bank: keypad read-modify-write cycling,
// full-bank fill, and arbitration of the single read port against VGA scan.
module color_bank_ctrl
  import color_bank_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] key_pos,
  input  logic          key_opr,
  input  logic          clr_req,
  input  logic [DW-1:0] fill_color,
  input  logic [AW-1:0] vga_addr,
  input  logic          vga_blank,
  input  logic [DW-1:0] bank_rdata,
  output logic [AW-1:0] bank_addrR,
  output logic [AW-1:0] bank_addrW,
  output logic [DW-1:0] bank_wdata,
  output logic          bank_we,
  output logic          busy,
  output logic          drop
);

  function automatic logic [DW-1:0] col_inc(input logic [DW-1:0] c);
    return c + DW'(1);
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [DW-1:0] fcol_q, fcol_d;
  logic [DW-1:0] fact_q, fact_d;
  logic          fpend_q, fpend_d;
  logic          key_opr_q;

  logic          press;
  logic          q_pop;
  logic          q_push;
  logic          q_full;
  logic          q_empty;
  logic [AW-1:0] q_head;

  assign press  = rst & key_opr & ~key_opr_q;
  assign q_pop  = rst & (state_q == ST_WR);
  assign q_push = press & (~q_full | q_pop);
  assign drop   = press & q_full & ~q_pop;

  press_queue #(
    .AW     (AW),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .din_i   (key_pos),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    fact_d  = fact_q;
    fpend_d = fpend_q;
    fcol_d  = fcol_q;
    case (state_q)
      ST_IDLE: begin
        if (fpend_q) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          fact_d  = fcol_q;
          fpend_d = 1'b0;
        end else if (!q_empty) begin
          state_d = ST_WAIT_BLK;
        end
      end
      ST_WAIT_BLK: begin
        if (vga_blank) state_d = ST_RD_MOD;
      end
      ST_RD_MOD: begin
        // Losing blanking mid-read means the data may belong to the scanner.
        if (vga_blank) begin
          cap_d   = col_inc(bank_rdata);
          state_d = ST_WR;
        end else begin
          state_d = ST_WAIT_BLK;
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_FILL: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fill request is remembered in any state, including a running fill.
    if (clr_req) begin
      fpend_d = 1'b1;
      fcol_d  = fill_color;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cap_q     <= '0;
      fcol_q    <= '0;
      fact_q    <= '0;
      fpend_q   <= 1'b0;
      key_opr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      fcol_q    <= fcol_d;
      fact_q    <= fact_d;
      fpend_q   <= fpend_d;
      key_opr_q <= key_opr;
    end
  end

  assign bank_addrR = (state_q == ST_RD_MOD) ? q_head : vga_addr;

  // Writes are gated by rst so an abandoned operation cannot land in the reset cycle.
  always_comb begin
    bank_we    = 1'b0;
    bank_addrW = '0;
    bank_wdata = '0;
    if (rst) begin
      if (state_q == ST_WR) begin
        bank_we    = 1'b1;
        bank_addrW = q_head;
        bank_wdata = cap_q;
      end else if (state_q == ST_FILL) begin
        bank_we    = 1'b1;
        bank_addrW = cnt_q;
        bank_wdata = fact_q;
      end
    end
  end

  assign busy = rst & ((state_q != ST_IDLE) | ~q_empty);

endmodule

// File: tb/tb_color_bank_ctrl.sv
// Bench for color_bank_ctrl: behavioural bank, write-order scoreboard, directed
// scenarios and a randomized phase.
module tb_color_bank_ctrl;

  localparam int AW = 4;
  localparam int DW = 3;
  localparam int QD = 2;
  localparam int NC = 1 << AW;
  localparam int CM = 1 << DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] key_pos;
  logic          key_opr;
  logic          clr_req;
  logic [DW-1:0] fill_color;
  logic [AW-1:0] vga_addr;
  logic          vga_blank;
  logic [DW-1:0] bank_rdata;
  logic [AW-1:0] bank_addrR;
  logic [AW-1:0] bank_addrW;
  logic [DW-1:0] bank_wdata;
  logic          bank_we;
  logic          busy;
  logic          drop;

  always #5 clk = ~clk;

  color_bank_ctrl #(.AW(AW), .DW(DW), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_pos    (key_pos),
    .key_opr    (key_opr),
    .clr_req    (clr_req),
    .fill_color (fill_color),
    .vga_addr   (vga_addr),
    .vga_blank  (vga_blank),
    .bank_rdata (bank_rdata),
    .bank_addrR (bank_addrR),
    .bank_addrW (bank_addrW),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we),
    .busy       (busy),
    .drop       (drop)
  );

  logic [DW-1:0] mem [NC];
  always @(posedge clk) if (bank_we) mem[bank_addrW] <= bank_wdata;
  assign bank_rdata = mem[bank_addrR];

  typedef struct {
    bit fill;
    int addr;
    int col;
  } wr_t;

  wr_t exp_q[$];
  int  model_mem[NC];
  int  n_chk = 0;
  int  n_pass = 0;
  int  s_we, s_addrW, s_wdata, s_addrR, s_busy, s_drop;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic mon();
    wr_t e;
    int  d;
    s_we    = int'(bank_we);
    s_addrW = int'(bank_addrW);
    s_wdata = int'(bank_wdata);
    s_addrR = int'(bank_addrR);
    s_busy  = int'(busy);
    s_drop  = int'(drop);
    if (bank_we) begin
      if (exp_q.size() == 0) begin
        check("unexp_we", s_we, 0);
      end else begin
        e = exp_q.pop_front();
        d = e.fill ? e.col : (model_mem[e.addr] + 1) % CM;
        check("wr_addr", s_addrW, e.addr);
        check("wr_data", s_wdata, d);
        model_mem[e.addr] = d;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic rcyc();
    vga_blank = 1'($urandom_range(0, 1));
    vga_addr  = AW'($urandom_range(0, NC - 1));
    cyc();
  endtask

  task automatic exp_press(input int p);
    exp_q.push_back('{1'b0, p, 0});
  endtask

  task automatic exp_fill(input int c);
    for (int i = 0; i < NC; i++) exp_q.push_back('{1'b1, i, c});
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int n = 0;
    do begin
      if (rnd) rcyc();
      else cyc();
      n++;
    end while ((s_busy != 0 || exp_q.size() != 0) && n < 300);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_busy"}, s_busy, 0);
  endtask

  task automatic do_fill(input string tag, input int c);
    clr_req    = 1'b1;
    fill_color = DW'(c);
    exp_fill(c);
    cyc();
    clr_req = 1'b0;
    wait_idle(tag, 1'b0);
  endtask

  task automatic wait_we(input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (s_we == 0 && n < budget);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pend;
    int expd;
    int va;
    rst = 1'b0; key_pos = '0; key_opr = 1'b0; clr_req = 1'b0;
    fill_color = '0; vga_addr = '0; vga_blank = 1'b1;

    // reset held while the keypad toggles
    for (int i = 0; i < 3; i++) begin
      key_opr = (i % 2 == 0);
      key_pos = AW'(i + 1);
      cyc();
      check("rst_we", s_we, 0);
      check("rst_busy", s_busy, 0);
      check("rst_drop", s_drop, 0);
    end
    key_opr = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_busy", s_busy, 0);
    check("post_rst_addrW", s_addrW, 0);
    check("post_rst_wdata", s_wdata, 0);

    // reset in the middle of a fill
    clr_req = 1'b1; fill_color = 3'd5; exp_fill(5);
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b0;
    cyc();
    check("rstmid_we", s_we, 0);
    rst = 1'b1;
    exp_q.delete();
    cyc();
    check("rstmid_busy", s_busy, 0);
    check("rstmid_we_after", s_we, 0);

    // single press on cell holding 3
    do_fill("fill3", 3);
    vga_blank = 1'b1; vga_addr = 4'd9;
    key_pos = 4'd5; key_opr = 1'b1; exp_press(5);
    cyc();
    key_opr = 1'b0;
    cyc();
    cyc();
    cyc();
    check("rd_addrR", s_addrR, 5);
    check("rd_we", s_we, 0);
    cyc();
    check("wr_we", s_we, 1);
    check("wr_addrW", s_addrW, 5);
    check("wr_wdata", s_wdata, 4);
    wait_idle("single", 1'b0);

    // wrap 7 -> 0 with blanking held off
    do_fill("fill7", 7);
    vga_blank = 1'b0;
    key_pos = 4'd2; key_opr = 1'b1; exp_press(2);
    for (int i = 0; i < 10; i++) begin
      va = $urandom_range(0, NC - 1);
      vga_addr = AW'(va);
      cyc();
      key_opr = 1'b0;
      check("wait_we", s_we, 0);
      check("wait_addrR", s_addrR, va);
    end
    vga_blank = 1'b1;
    wait_we(10);
    check("wrap_we", s_we, 1);
    check("wrap_addrW", s_addrW, 2);
    check("wrap_wdata", s_wdata, 0);
    wait_idle("wrap", 1'b0);

    // blanking lost during the read cycle
    vga_blank = 1'b1; vga_addr = 4'd0;
    key_pos = 4'd9; key_opr = 1'b1; exp_press(9);
    cyc();
    key_opr = 1'b0;
    cyc();
    cyc();
    vga_blank = 1'b0;
    cyc();
    check("blk_rd_addrR", s_addrR, 9);
    check("blk_rd_we", s_we, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("blk_hold_we", s_we, 0);
    end
    vga_blank = 1'b1;
    wait_we(10);
    check("blk_we", s_we, 1);
    check("blk_addrW", s_addrW, 9);
    wait_idle("blkdrop", 1'b0);

    // overflow: third press while two are pending and no blanking
    vga_blank = 1'b0;
    pend = 0;
    for (int k = 0; k < 3; k++) begin
      key_pos = AW'(k + 1); key_opr = 1'b1;
      expd = (pend == QD) ? 1 : 0;
      if (expd == 0) begin
        exp_press(k + 1);
        pend++;
      end
      cyc();
      check("ovf_drop", s_drop, expd);
      key_opr = 1'b0;
      cyc();
      check("ovf_drop_rel", s_drop, 0);
    end
    vga_blank = 1'b1;
    wait_idle("ovf", 1'b0);

    // fill requested while an RMW is writing
    vga_blank = 1'b1;
    key_pos = 4'd4; key_opr = 1'b1; exp_press(4);
    cyc();
    key_opr = 1'b0;
    cyc();
    cyc();
    cyc();
    clr_req = 1'b1; fill_color = 3'd6; exp_fill(6);
    cyc();
    clr_req = 1'b0;
    check("fwr_we", s_we, 1);
    check("fwr_addrW", s_addrW, 4);
    cyc();
    check("fwr_gap_we", s_we, 0);
    for (int i = 0; i < NC; i++) begin
      cyc();
      check("fill_we", s_we, 1);
    end
    cyc();
    check("fill_end_we", s_we, 0);
    check("fill_end_busy", s_busy, 0);

    // randomized operations, one at a time, random blanking
    for (int it = 0; it < 30; it++) begin
      int op;
      int p1;
      int p2;
      op = $urandom_range(0, 2);
      p1 = $urandom_range(0, NC - 1);
      p2 = $urandom_range(0, NC - 1);
      if (op == 0) begin
        key_pos = AW'(p1); key_opr = 1'b1; exp_press(p1);
        rcyc();
        check("rnd_drop", s_drop, 0);
        key_opr = 1'b0;
        wait_idle("rnd1", 1'b1);
      end else if (op == 1) begin
        key_pos = AW'(p1); key_opr = 1'b1; exp_press(p1);
        rcyc();
        key_opr = 1'b0;
        rcyc();
        key_pos = AW'(p2); key_opr = 1'b1; exp_press(p2);
        rcyc();
        check("rnd_drop2", s_drop, 0);
        key_opr = 1'b0;
        wait_idle("rnd2", 1'b1);
      end else begin
        clr_req = 1'b1; fill_color = DW'(p1 % CM); exp_fill(p1 % CM);
        rcyc();
        clr_req = 1'b0;
        wait_idle("rndf", 1'b1);
      end
    end

    for (int i = 0; i < NC; i++) check("bank_cell", int'(mem[i]), model_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
